// File: rtl/player_state_module.sv
// Per-frame player/camera state engine.
// On each new_frame pulse the heading is rotated according to the latched mode.
// In manual mode with forward or back pressed, the engine fetches cos/sin from
// an external trig ROM, advances the position and clamps it to the map bounds.
// Heading and position are committed together, so a reader never sees a half update.
module player_state_module #(
  parameter int INT_W     = 8,
  parameter int FRAC_W    = 8,
  parameter int ANGLE_W   = 8,
  parameter int TRIG_W    = 10,
  parameter int MOVE_STEP = 64,
  parameter int SPIN_STEP = 1,
  parameter int MIN_POS   = 16,
  parameter int MAX_POS   = 240,
  parameter int INIT_X    = 128,
  parameter int INIT_Y    = 128
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      new_frame,
  input  logic [1:0]                mode,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_fwd,
  input  logic                      btn_back,
  output logic                      trig_req,
  output logic [ANGLE_W-1:0]        trig_angle,
  input  logic                      trig_ack,
  input  logic [TRIG_W-1:0]         cos_in,
  input  logic [TRIG_W-1:0]         sin_in,
  output logic [INT_W+FRAC_W-1:0]   pos_x,
  output logic [INT_W+FRAC_W-1:0]   pos_y,
  output logic [ANGLE_W-1:0]        player_angle,
  output logic                      busy,
  output logic [7:0]                frames_missed
);

  localparam int POS_W  = INT_W + FRAC_W;
  localparam int CAND_W = POS_W + 2;            // sign + carry headroom
  localparam int PROD_W = TRIG_W + POS_W + 1;

  localparam logic [ANGLE_W-1:0]       SPIN_V     = ANGLE_W'(SPIN_STEP);
  localparam logic [ANGLE_W-1:0]       ANGLE_ZERO = {ANGLE_W{1'b0}};
  localparam logic signed [PROD_W-1:0] STEP_EXT   = PROD_W'(MOVE_STEP);
  localparam logic signed [CAND_W-1:0] MIN_C      = CAND_W'(MIN_POS << FRAC_W);
  localparam logic signed [CAND_W-1:0] MAX_C      = CAND_W'(MAX_POS << FRAC_W);
  localparam logic [POS_W-1:0]         MIN_V      = POS_W'(MIN_POS << FRAC_W);
  localparam logic [POS_W-1:0]         MAX_V      = POS_W'(MAX_POS << FRAC_W);
  localparam logic [POS_W-1:0]         INIT_X_V   = POS_W'(INIT_X << FRAC_W);
  localparam logic [POS_W-1:0]         INIT_Y_V   = POS_W'(INIT_Y << FRAC_W);

  typedef enum logic [2:0] {IDLE, ROTATE, TRIG_REQ, MOVE, COMMIT} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 mode_q, mode_d;
  logic                       left_q, left_d, right_q, right_d;
  logic                       fwd_q, fwd_d, back_q, back_d;
  logic [ANGLE_W-1:0]         next_angle_q, next_angle_d;
  logic [TRIG_W-1:0]          cos_q, cos_d, sin_q, sin_d;
  logic signed [CAND_W-1:0]   cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [POS_W-1:0]           pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [ANGLE_W-1:0]         angle_q, angle_d;
  logic                       busy_q, busy_d;
  logic                       trig_req_q, trig_req_d;
  logic [ANGLE_W-1:0]         trig_angle_q, trig_angle_d;
  logic [7:0]                 missed_q, missed_d;

  logic [ANGLE_W-1:0]         delta_s;
  logic                       move_s;
  logic signed [PROD_W-1:0]   prod_x_s, prod_y_s, shx_s, shy_s;
  logic signed [CAND_W-1:0]   dx_s, dy_s, cand_x_s, cand_y_s;

  // Clamp one candidate axis into the inclusive map bounds; negatives land on min.
  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [CAND_W-1:0] c);
    if (c < MIN_C) begin
      return MIN_V;
    end else if (c > MAX_C) begin
      return MAX_V;
    end else begin
      return POS_W'(c);
    end
  endfunction

  // Heading change for this frame from the latched mode and buttons.
  always_comb begin
    delta_s = ANGLE_ZERO;
    case (mode_q)
      2'b01: delta_s = SPIN_V;
      2'b10: begin
        if (right_q && !left_q) begin
          delta_s = SPIN_V;
        end else if (left_q && !right_q) begin
          delta_s = -SPIN_V;
        end else begin
          delta_s = ANGLE_ZERO;
        end
      end
      default: delta_s = ANGLE_ZERO;
    endcase
  end

  assign move_s = (mode_q == 2'b10) && (fwd_q ^ back_q);

  // Scaled step per axis: trig sample times step, arithmetic shift floors toward -inf.
  always_comb begin
    prod_x_s = {{(PROD_W-TRIG_W){cos_q[TRIG_W-1]}}, cos_q} * STEP_EXT;
    prod_y_s = {{(PROD_W-TRIG_W){sin_q[TRIG_W-1]}}, sin_q} * STEP_EXT;
    shx_s    = prod_x_s >>> (TRIG_W - 2);
    shy_s    = prod_y_s >>> (TRIG_W - 2);
    dx_s     = CAND_W'(back_q ? -shx_s : shx_s);
    dy_s     = CAND_W'(back_q ? -shy_s : shy_s);
    cand_x_s = dx_s + $signed({2'b00, pos_x_q});
    cand_y_s = dy_s + $signed({2'b00, pos_y_q});
  end

  // Next-state and next-output logic of the update sequencer.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    left_d       = left_q;
    right_d      = right_q;
    fwd_d        = fwd_q;
    back_d       = back_q;
    next_angle_d = next_angle_q;
    cos_d        = cos_q;
    sin_d        = sin_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    angle_d      = angle_q;
    busy_d       = busy_q;
    trig_req_d   = trig_req_q;
    trig_angle_d = trig_angle_q;
    missed_d     = missed_q;

    if (new_frame && (state_q != IDLE) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end else begin
      missed_d = missed_q;
    end

    case (state_q)
      IDLE: begin
        if (new_frame) begin
          mode_d  = mode;
          left_d  = btn_left;
          right_d = btn_right;
          fwd_d   = btn_fwd;
          back_d  = btn_back;
          busy_d  = 1'b1;
          state_d = ROTATE;
        end else begin
          state_d = IDLE;
        end
      end
      ROTATE: begin
        next_angle_d = angle_q + delta_s;
        cand_x_d     = $signed({2'b00, pos_x_q});
        cand_y_d     = $signed({2'b00, pos_y_q});
        if (move_s) begin
          trig_req_d   = 1'b1;
          trig_angle_d = angle_q + delta_s;
          state_d      = TRIG_REQ;
        end else begin
          state_d = COMMIT;
        end
      end
      TRIG_REQ: begin
        if (trig_ack) begin
          cos_d      = cos_in;
          sin_d      = sin_in;
          trig_req_d = 1'b0;
          state_d    = MOVE;
        end else begin
          state_d = TRIG_REQ;
        end
      end
      MOVE: begin
        cand_x_d = cand_x_s;
        cand_y_d = cand_y_s;
        state_d  = COMMIT;
      end
      COMMIT: begin
        pos_x_d = clamp_pos(cand_x_q);
        pos_y_d = clamp_pos(cand_y_q);
        angle_d = next_angle_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d     = 1'b0;
        trig_req_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears an in-flight request immediately.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      mode_q       <= 2'b00;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      fwd_q        <= 1'b0;
      back_q       <= 1'b0;
      next_angle_q <= ANGLE_ZERO;
      cos_q        <= {TRIG_W{1'b0}};
      sin_q        <= {TRIG_W{1'b0}};
      cand_x_q     <= {CAND_W{1'b0}};
      cand_y_q     <= {CAND_W{1'b0}};
      pos_x_q      <= INIT_X_V;
      pos_y_q      <= INIT_Y_V;
      angle_q      <= ANGLE_ZERO;
      busy_q       <= 1'b0;
      trig_req_q   <= 1'b0;
      trig_angle_q <= ANGLE_ZERO;
      missed_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      left_q       <= left_d;
      right_q      <= right_d;
      fwd_q        <= fwd_d;
      back_q       <= back_d;
      next_angle_q <= next_angle_d;
      cos_q        <= cos_d;
      sin_q        <= sin_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      angle_q      <= angle_d;
      busy_q       <= busy_d;
      trig_req_q   <= trig_req_d;
      trig_angle_q <= trig_angle_d;
      missed_q     <= missed_d;
    end
  end

  assign trig_req      = trig_req_q;
  assign trig_angle    = trig_angle_q;
  assign pos_x         = pos_x_q;
  assign pos_y         = pos_y_q;
  assign player_angle  = angle_q;
  assign busy          = busy_q;
  assign frames_missed = missed_q;

endmodule

// File: doc/player_state_module.md
Name: player_state_module

Overview:
Per-frame player/camera state engine that replaces the hard-wired player position and free-running spin counter at the top level. On every new_frame pulse it updates player_angle and player position from a selectable mode (hold, auto-spin, manual), fetching cos/sin from an external trig ROM over a req/ack handshake. It clamps position to map bounds and presents the new angle and position to the render module atomically.

Parameters:
INT_W, 8, integer bits of each position coordinate
FRAC_W, 8, fractional bits of each position coordinate
ANGLE_W, 8, angle width; full turn = 2^ANGLE_W
TRIG_W, 10, signed trig sample width, Q1.(TRIG_W-2); 1.0 = 2^(TRIG_W-2)
MOVE_STEP, 64, forward step per frame in position LSBs (unsigned, FRAC_W+INT_W bits)
SPIN_STEP, 1, angle increment per frame
MIN_POS, 16, minimum integer coordinate (inclusive)
MAX_POS, 240, maximum integer coordinate (inclusive)
INIT_X, 128, reset integer x
INIT_Y, 128, reset integer y

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
new_frame  in  1  single-cycle pulse from output module at frame start
mode  in  2  00 hold, 01 auto-spin, 10 manual, 11 treated as hold
btn_left, btn_right, btn_fwd, btn_back  in  1 each  manual controls, level
trig_req  out  1  trig lookup request
trig_angle  out  ANGLE_W  angle for lookup
trig_ack  in  1  cos_in/sin_in valid this cycle
cos_in, sin_in  in  TRIG_W  signed trig results
pos_x, pos_y  out  INT_W+FRAC_W  player position, unsigned fixed point
player_angle  out  ANGLE_W  player heading
busy  out  1  update in progress
frames_missed  out  8  saturating count of dropped new_frame pulses

Behaviour:
- Reset (async, Reset_n low): state IDLE; pos_x = INIT_X<<FRAC_W, pos_y = INIT_Y<<FRAC_W; player_angle = 0; trig_req = 0; trig_angle = 0; busy = 0; frames_missed = 0. trig_req drops immediately on reset assertion, even mid-handshake.
- States: IDLE, ROTATE, TRIG_REQ, MOVE, COMMIT.
- IDLE: on new_frame, latch mode and all four buttons -> ROTATE. busy goes high on the same edge. Inputs are sampled only at this edge.
- ROTATE: next_angle = player_angle + delta, where delta is:
  - auto: +SPIN_STEP
  - manual: +SPIN_STEP if right only, -SPIN_STEP if left only, 0 if both or neither
  - hold: 0
  - Angle wraps modulo 2^ANGLE_W.
  - Next state is TRIG_REQ if manual and (fwd XOR back); otherwise COMMIT.
- TRIG_REQ: trig_req = 1 and trig_angle = next_angle, both held stable until trig_ack is sampled high. On the ack edge, capture cos_in/sin_in -> MOVE. Wait is unbounded.
- MOVE: dx = (cos * MOVE_STEP) >>> (TRIG_W-2), dy likewise with sin. Arithmetic shift, truncation toward -inf. Negate both when back is pressed. Candidate = pos + d, computed with 2 extra bits (sign + carry) so no wrap occurs -> COMMIT.
- COMMIT: clamp each axis independently to [MIN_POS<<FRAC_W, MAX_POS<<FRAC_W]; a negative candidate clamps to min. player_angle, pos_x and pos_y register together on this edge -> IDLE; busy deasserts on the same edge.
- If no movement occurred, position is unchanged.
- Latency without movement: new_frame sampled at edge E0; outputs updated at E2; busy high E0..E2.
- Latency with movement: outputs update 2 edges after the ack edge.
- new_frame while not IDLE (including in COMMIT): ignored; frames_missed += 1, saturating at 255. The in-progress update completes normally.
- new_frame in the same cycle that the FSM returns to IDLE is missed (counted), not queued.
- Outputs never show a partial update. Render reads remain consistent at all times.

Test Plan:
1. Reset_n low then high, mode=00, pulse new_frame -> pos_x = pos_y = 0x8000, player_angle = 0, busy high for exactly 2 cycles, trig_req never asserts.
2. Auto mode, 256 new_frame pulses spaced 100 cycles -> player_angle steps 1..255 then wraps to 0; frames_missed = 0.
3. Manual, btn_left only, angle 0 -> angle 255 after update. btn_left+btn_right together -> angle unchanged.
4. Manual fwd, angle 0; ROM returns cos=256, sin=0 after 5-cycle ack delay -> trig_req held 5 cycles with trig_angle=0; pos_x 0x8000 -> 0x8040, pos_y unchanged.
5. Manual back, pos_x = 0x1000 (min), cos=256 -> pos_x clamped at 0x1000. Manual fwd at pos_x = 0xF000 -> stays 0xF000.
6. During TRIG_REQ, pulse new_frame 3 times, then assert Reset_n low mid-wait -> frames_missed reached 3 before reset; trig_req drops asynchronously; all outputs return to reset values.
